// File: rtl/fpu_pkg.sv
// Shared constants for the int->float conversion scheduler: FSM state encodings,
// the watchdog qNaN pattern and the requester-id width helper.
package fpu_pkg;

   localparam int unsigned OPW = 32;

   typedef logic [1:0] sched_state_t;

   localparam sched_state_t S_IDLE  = 2'd0;
   localparam sched_state_t S_ISSUE = 2'd1;
   localparam sched_state_t S_WAIT  = 2'd2;
   localparam sched_state_t S_RESP  = 2'd3;

   localparam logic [OPW-1:0] FPU_QNAN = 32'h7FC0_0000;

   // A single requester still needs a 1-bit id field.
   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fpu_rr_arb.sv
// Combinational round-robin picker: the first asserted request at or after rr_ptr,
// wrapping modulo NREQ; returns a one-hot grant and its encoded index.
module fpu_rr_arb
   import fpu_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  rr_ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   int best;
   int off;

   // Smallest distance from rr_ptr (mod NREQ) among the asserted requests wins.
   always_comb begin
      idx  = '0;
      best = int'(NREQ);
      off  = 0;
      for (int i = 0; i < int'(NREQ); i++) begin
         off = i + int'(NREQ) - int'(rr_ptr);
         if (off >= int'(NREQ)) off = off - int'(NREQ);
         if (req[i] && (off < best)) begin
            best = off;
            idx  = IDW'(i);
         end
      end
   end

   assign any   = |req;
   assign grant = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/fpu_conv_sched.sv
// Shares one multi-cycle int->float converter among NREQ round-robin requesters.
// Optional WAIT-state watchdog enabled by defining FPU_SCHED_WDOG_EN.
module fpu_conv_sched
   import fpu_pkg::*;
#(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned IDW         = id_width(NREQ),
   parameter int unsigned WDOG_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*32-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              cv_start,
   output logic [31:0]       cv_in,
   input  logic              cv_done,
   input  logic [31:0]       cv_out,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [IDW-1:0]    resp_id,
   output logic [31:0]       resp_data,
   output logic              resp_err
);

   sched_state_t    state;
   sched_state_t    state_nxt;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_idx;
   logic            grant_any;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  ptr_nxt;
   logic [31:0]     op_sel;
   logic            accept;
   logic            wdog_to;
   logic            wait_end;

   fpu_rr_arb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req    (req_valid),
      .rr_ptr (rr_ptr),
      .grant  (grant),
      .idx    (grant_idx),
      .any    (grant_any)
   );

   // Ready is offered only in IDLE and never while reset is being applied.
   assign accept    = (state == S_IDLE) && grant_any && rst;
   assign req_ready = accept ? grant : '0;
   assign ptr_nxt   = (grant_idx == IDW'(NREQ - 1)) ? '0 : (grant_idx + IDW'(1));

   always_comb begin
      op_sel = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant[i]) op_sel = req_data[32*i +: 32];
      end
   end

`ifdef FPU_SCHED_WDOG_EN
   localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);

   logic [WDW-1:0] wdog_cnt;

   // Counts completed WAIT cycles; held at zero outside WAIT.
   always_ff @(posedge clk) begin
      if (!rst)                 wdog_cnt <= '0;
      else if (state != S_WAIT) wdog_cnt <= '0;
      else                      wdog_cnt <= wdog_cnt + WDW'(1);
   end

   assign wdog_to = (state == S_WAIT) && (wdog_cnt == WDW'(WDOG_CYCLES - 1));
`else
   assign wdog_to = 1'b0;
`endif

   assign wait_end = (state == S_WAIT) && (cv_done || wdog_to);

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)     state_nxt = S_ISSUE;
         S_ISSUE:                 state_nxt = S_WAIT;
         S_WAIT:  if (wait_end)   state_nxt = S_RESP;
         S_RESP:  if (resp_ready) state_nxt = S_IDLE;
         default:                 state_nxt = S_IDLE;
      endcase
   end

   // A real cv_done beats a watchdog expiry in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr     <= '0;
         cv_start   <= 1'b0;
         cv_in      <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
      end else begin
         cv_start <= accept;
         if (accept) begin
            cv_in   <= op_sel;
            resp_id <= grant_idx;
            rr_ptr  <= ptr_nxt;
         end
         if (wait_end) begin
            resp_valid <= 1'b1;
            resp_data  <= cv_done ? cv_out : FPU_QNAN;
            resp_err   <= ~cv_done;
         end else if ((state == S_RESP) && resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end

endmodule
